// File: rtl/sdram_wb_arbiter.sv
// Three-master Wishbone arbiter in front of the SDRAM controller: fixed priority
// video > sound > CPU, with a CPU starvation override and an idle cycle between grants.
module sdram_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 64,
    parameter int unsigned CNT_W        = 7
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,

    input  logic        cpu_cyc,
    input  logic        cpu_stb,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_sel,
    input  logic [21:0] cpu_adr,
    input  logic [31:0] cpu_dat_i,
    input  logic [2:0]  cpu_cti,
    output logic        cpu_ack,

    input  logic        vid_cyc,
    input  logic [21:0] vid_adr,
    input  logic [2:0]  vid_cti,
    output logic        vid_ack,

    input  logic        snd_cyc,
    input  logic [21:0] snd_adr,
    output logic        snd_ack,

    output logic [31:0] m_dat_o,

    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [3:0]  s_sel,
    output logic [21:0] s_adr,
    output logic [31:0] s_dat_o,
    output logic [2:0]  s_cti,
    input  logic        s_ack,
    input  logic [31:0] s_dat_i,

    output logic [1:0]  gnt
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'b00,
        GNT_CPU  = 2'b01,
        GNT_VID  = 2'b10,
        GNT_SND  = 2'b11
    } gnt_t;

    gnt_t             gnt_q;
    gnt_t             gnt_d;
    logic [CNT_W-1:0] starve_cnt;
    logic             cpu_req;
    logic             starved;

    assign cpu_req = cpu_cyc & cpu_stb;
    assign starved = (starve_cnt >= CNT_W'(STARVE_LIMIT));
    assign gnt     = gnt_q;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            gnt_q <= GNT_NONE;
        end else begin
            gnt_q <= gnt_d;
        end
    end

    // Grant only ever moves through GNT_NONE, so the controller always sees a fresh stb edge.
    always_comb begin
        gnt_d = gnt_q;
        case (gnt_q)
            GNT_NONE: begin
                if (cpu_req && starved) gnt_d = GNT_CPU;
                else if (vid_cyc)       gnt_d = GNT_VID;
                else if (snd_cyc)       gnt_d = GNT_SND;
                else if (cpu_req)       gnt_d = GNT_CPU;
                else                    gnt_d = GNT_NONE;
            end
            GNT_CPU: if (!cpu_cyc) gnt_d = GNT_NONE;
            GNT_VID: if (!vid_cyc) gnt_d = GNT_NONE;
            GNT_SND: if (!snd_cyc) gnt_d = GNT_NONE;
            default: gnt_d = GNT_NONE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            starve_cnt <= '0;
        end else if (gnt_d == GNT_CPU && gnt_q != GNT_CPU) begin
            starve_cnt <= '0;
        end else if (cpu_req && gnt_q != GNT_CPU && starve_cnt != '1) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat_o = '0;
        s_cti   = '0;
        case (gnt_q)
            GNT_CPU: begin
                s_cyc   = cpu_cyc;
                s_stb   = cpu_stb;
                s_we    = cpu_we;
                s_sel   = cpu_sel;
                s_adr   = cpu_adr;
                s_dat_o = cpu_dat_i;
                s_cti   = cpu_cti;
            end
            GNT_VID: begin
                s_cyc   = vid_cyc;
                s_stb   = vid_cyc;
                s_sel   = '1;
                s_adr   = vid_adr;
                s_cti   = vid_cti;
            end
            GNT_SND: begin
                s_cyc   = snd_cyc;
                s_stb   = snd_cyc;
                s_sel   = '1;
                s_adr   = snd_adr;
            end
            default: ;
        endcase
    end

    assign cpu_ack = s_ack & (gnt_q == GNT_CPU);
    assign vid_ack = s_ack & (gnt_q == GNT_VID);
    assign snd_ack = s_ack & (gnt_q == GNT_SND);
    assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed bench for sdram_wb_arbiter: hand-computed grant sequences, mux and ack routing.
module tb_sdram_wb_arbiter;

    logic        wb_clk;
    logic        wb_rst_n;
    logic        cpu_cyc, cpu_stb, cpu_we;
    logic [3:0]  cpu_sel;
    logic [21:0] cpu_adr;
    logic [31:0] cpu_dat_i;
    logic [2:0]  cpu_cti;
    logic        cpu_ack;
    logic        vid_cyc;
    logic [21:0] vid_adr;
    logic [2:0]  vid_cti;
    logic        vid_ack;
    logic        snd_cyc;
    logic [21:0] snd_adr;
    logic        snd_ack;
    logic [31:0] m_dat_o;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [21:0] s_adr;
    logic [31:0] s_dat_o;
    logic [2:0]  s_cti;
    logic        s_ack;
    logic [31:0] s_dat_i;
    logic [1:0]  gnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] prev_gnt = 2'b00;

    sdram_wb_arbiter #(.STARVE_LIMIT(64), .CNT_W(7)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
        .cpu_adr(cpu_adr), .cpu_dat_i(cpu_dat_i), .cpu_cti(cpu_cti), .cpu_ack(cpu_ack),
        .vid_cyc(vid_cyc), .vid_adr(vid_adr), .vid_cti(vid_cti), .vid_ack(vid_ack),
        .snd_cyc(snd_cyc), .snd_adr(snd_adr), .snd_ack(snd_ack),
        .m_dat_o(m_dat_o),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel), .s_adr(s_adr),
        .s_dat_o(s_dat_o), .s_cti(s_cti), .s_ack(s_ack), .s_dat_i(s_dat_i),
        .gnt(gnt)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge wb_clk);
        #1;
    endtask

    // Every grant change must pass through none, and an idle arbiter drives nothing.
    always @(negedge wb_clk) begin
        if (gnt != prev_gnt)
            check_eq("gnt_gap", 32'((prev_gnt == 2'b00) || (gnt == 2'b00)), 32'd1);
        if (gnt == 2'b00)
            check_eq("idle_stb", 32'(s_cyc | s_stb), 32'd0);
        prev_gnt = gnt;
    end

    initial begin
        wb_rst_n = 1'b0;
        cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; cpu_sel = '0; cpu_adr = '0;
        cpu_dat_i = '0; cpu_cti = '0;
        vid_cyc = 0; vid_adr = '0; vid_cti = '0;
        snd_cyc = 0; snd_adr = '0;
        s_ack = 1'b1; s_dat_i = '0;

        // Reset state, with a stray slave ack that must be discarded
        tick; tick;
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_scyc", 32'(s_cyc), 32'd0);
        check_eq("rst_acks", 32'({cpu_ack, vid_ack, snd_ack}), 32'd0);
        s_ack = 1'b0;
        wb_rst_n = 1'b1;
        tick;

        // CPU single read, slave acks three cycles after strobe
        cpu_cyc = 1; cpu_stb = 1; cpu_we = 0; cpu_sel = 4'hF; cpu_adr = 22'h000100;
        tick;
        check_eq("rd_gnt", 32'(gnt), 32'd1);
        check_eq("rd_stb", 32'(s_stb), 32'd1);
        check_eq("rd_adr", 32'(s_adr), 32'h000100);
        check_eq("rd_we", 32'(s_we), 32'd0);
        check_eq("rd_noack", 32'(cpu_ack), 32'd0);
        tick; tick;
        s_ack = 1; s_dat_i = 32'hCAFE_F00D;
        #1;
        check_eq("rd_ack", 32'(cpu_ack), 32'd1);
        check_eq("rd_vidack", 32'(vid_ack), 32'd0);
        check_eq("rd_dat", m_dat_o, 32'hCAFE_F00D);
        tick;
        cpu_cyc = 0; cpu_stb = 0; s_ack = 0;
        #1;
        check_eq("rd_ack_1cyc", 32'(cpu_ack), 32'd0);
        check_eq("rd_gnt_hold", 32'(gnt), 32'd1);
        tick;
        check_eq("rd_gnt_rel", 32'(gnt), 32'd0);

        // Video burst; sound and CPU request mid-burst
        vid_cyc = 1; vid_adr = 22'h001000; vid_cti = 3'b010; snd_adr = 22'h002000;
        tick;
        check_eq("vid_gnt", 32'(gnt), 32'd2);
        check_eq("vid_cti", 32'(s_cti), 32'd2);
        check_eq("vid_sel", 32'(s_sel), 32'hF);
        check_eq("vid_adr", 32'(s_adr), 32'h001000);
        check_eq("vid_we", 32'(s_we), 32'd0);
        for (int i = 0; i < 4; i++) begin
            s_ack = 1; s_dat_i = 32'(i) + 32'h100;
            if (i == 1) begin
                snd_cyc = 1; cpu_cyc = 1; cpu_stb = 1; cpu_adr = 22'h000200;
            end
            #1;
            check_eq("burst_vidack", 32'(vid_ack), 32'd1);
            check_eq("burst_other", 32'({cpu_ack, snd_ack}), 32'd0);
            tick;
        end
        vid_cyc = 0; s_ack = 0;
        tick;
        check_eq("burst_gap", 32'(gnt), 32'd0);
        tick;
        check_eq("snd_gnt", 32'(gnt), 32'd3);
        check_eq("snd_adr", 32'(s_adr), 32'h002000);
        check_eq("snd_cti", 32'(s_cti), 32'd0);
        s_ack = 1;
        #1;
        check_eq("snd_ack", 32'({cpu_ack, vid_ack, snd_ack}), 32'b001);
        tick;
        snd_cyc = 0; s_ack = 0;
        tick;
        check_eq("snd_rel", 32'(gnt), 32'd0);
        tick;
        check_eq("cpu_after_snd", 32'(gnt), 32'd1);
        check_eq("cpu_adr2", 32'(s_adr), 32'h000200);
        s_ack = 1;
        tick;
        cpu_cyc = 0; cpu_stb = 0; s_ack = 0;
        tick;

        // CPU write from idle
        cpu_cyc = 1; cpu_stb = 1; cpu_we = 1; cpu_sel = 4'b0011;
        cpu_dat_i = 32'hDEAD_BEEF; cpu_adr = 22'h000300;
        tick;
        check_eq("wr_gnt", 32'(gnt), 32'd1);
        check_eq("wr_we", 32'(s_we), 32'd1);
        check_eq("wr_sel", 32'(s_sel), 32'h3);
        check_eq("wr_dat", s_dat_o, 32'hDEAD_BEEF);
        s_ack = 1;
        tick;
        cpu_cyc = 0; cpu_stb = 0; cpu_we = 0; s_ack = 0;
        tick;
        check_eq("wr_rel", 32'(gnt), 32'd0);
        check_eq("wr_cnt", 32'(dut.starve_cnt), 32'd0);

        // All three request together, then CPU starves: 63 waits loses, 65 wins
        vid_cyc = 1; snd_cyc = 1; cpu_cyc = 1; cpu_stb = 1;
        tick;
        check_eq("simul_vid", 32'(gnt), 32'd2);
        repeat (61) tick;
        vid_cyc = 0;
        tick;
        check_eq("starve_gap1", 32'(gnt), 32'd0);
        vid_cyc = 1;
        tick;
        check_eq("starve_63", 32'(gnt), 32'd2);
        vid_cyc = 0;
        tick;
        check_eq("starve_gap2", 32'(gnt), 32'd0);
        vid_cyc = 1;
        tick;
        check_eq("starve_cpu", 32'(gnt), 32'd1);
        check_eq("starve_clr", 32'(dut.starve_cnt), 32'd0);
        cpu_cyc = 0; cpu_stb = 0; vid_cyc = 0; snd_cyc = 0;
        tick;
        check_eq("starve_rel", 32'(gnt), 32'd0);
        tick;

        // Reset in the middle of a video burst
        vid_cyc = 1;
        tick;
        check_eq("rst2_gnt", 32'(gnt), 32'd2);
        s_ack = 1;
        tick;
        #2;
        wb_rst_n = 0;
        #1;
        check_eq("rst2_scyc", 32'(s_cyc), 32'd0);
        check_eq("rst2_vidack", 32'(vid_ack), 32'd0);
        check_eq("rst2_gnt0", 32'(gnt), 32'd0);
        vid_cyc = 0; s_ack = 0;
        tick;
        wb_rst_n = 1;
        tick;
        check_eq("rst2_after", 32'(gnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_wb_arbiter.md
Name: sdram_wb_arbiter

Overview:
- Three-master Wishbone arbiter that shares the single SDRAM controller port between the CPU, video DMA and sound DMA. All three run on the 32 MHz chipset clock.
- Uses fixed priority (video > sound > CPU) with a CPU anti-starvation override.
- Holds the grant for the whole Wishbone cycle, so bursts are never split.
- Forces at least one idle cycle between grants so the controller sees a fresh stb rising edge for every new request.

Parameters:
STARVE_LIMIT, 64, CPU wait cycles after which the CPU wins the next arbitration over all masters.
CNT_W, 7, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
wb_clk  in  1  chipset clock; all logic on rising edge
wb_rst_n  in  1  asynchronous, active-low reset
cpu_cyc  in  1  CPU Wishbone cycle
cpu_stb  in  1  CPU strobe
cpu_we  in  1  CPU write enable
cpu_sel  in  4  CPU byte selects
cpu_adr  in  22  CPU word address [23:2]
cpu_dat_i  in  32  CPU write data
cpu_cti  in  3  CPU cycle type
cpu_ack  out  1  ack to CPU
vid_cyc  in  1  video DMA request (acts as cyc and stb), read-only
vid_adr  in  22  video word address [23:2]
vid_cti  in  3  video cycle type (normally 3'b010 incrementing burst)
vid_ack  out  1  ack to video
snd_cyc  in  1  sound DMA request (acts as cyc and stb), read-only, single word
snd_adr  in  22  sound word address [23:2]
snd_ack  out  1  ack to sound
m_dat_o  out  32  read data broadcast to all masters
s_cyc  out  1  cycle to SDRAM controller
s_stb  out  1  strobe to controller
s_we  out  1  write enable to controller
s_sel  out  4  byte selects to controller
s_adr  out  22  address to controller
s_dat_o  out  32  write data to controller
s_cti  out  3  cycle type to controller
s_ack  in  1  ack from controller
s_dat_i  in  32  read data from controller
gnt  out  2  current grant: 00 none, 01 CPU, 10 video, 11 sound

Behaviour:
- States:
  - IDLE (gnt=00).
  - GRANT (gnt!=00). The gnt register is the state.
- Reset:
  - While wb_rst_n=0, asynchronously: gnt=00, starvation counter=0.
  - All s_* outputs and acks are decoded from gnt, so they are 0 immediately.
  - A reset mid-transfer drops s_cyc/s_stb at once. Any s_ack arriving while gnt=00 is discarded.
- IDLE arbitration, evaluated each edge:
  - Requests: cpu_req = cpu_cyc&cpu_stb, vid_req = vid_cyc, snd_req = snd_cyc.
  - If cpu_req and counter>=STARVE_LIMIT → gnt=01.
  - Else vid_req → 10; else snd_req → 11; else cpu_req → 01; else stay 00.
  - Grant latency: a request sampled in IDLE at edge N gives gnt valid and s_stb high from edge N+1.
- GRANT:
  - Holds while the granted master's cyc is 1 (cpu_cyc, vid_cyc or snd_cyc respectively).
  - When that cyc is sampled 0 → gnt=00.
  - No direct GRANT→GRANT transition: there is always ≥1 cycle with s_cyc=s_stb=0 between masters.
  - A request by another master during GRANT is held off, not lost.
- Slave mux (combinational from gnt):
  - gnt=00: all s_* = 0.
  - gnt=01: s_cyc=cpu_cyc, s_stb=cpu_stb, s_we=cpu_we, s_sel=cpu_sel, s_adr=cpu_adr, s_dat_o=cpu_dat_i, s_cti=cpu_cti.
  - gnt=10: s_cyc=s_stb=vid_cyc, s_we=0, s_sel=4'hF, s_adr=vid_adr, s_dat_o=0, s_cti=vid_cti.
  - gnt=11: s_cyc=s_stb=snd_cyc, s_we=0, s_sel=4'hF, s_adr=snd_adr, s_dat_o=0, s_cti=3'b000.
- Ack routing and read data:
  - cpu_ack = s_ack&(gnt==01); vid_ack = s_ack&(gnt==10); snd_ack = s_ack&(gnt==11).
  - m_dat_o = s_dat_i unconditionally.
- Starvation counter:
  - Increments (saturating at 2^CNT_W-1) each cycle cpu_req=1 and gnt!=01.
  - Clears to 0 on the edge where gnt becomes 01.
  - Holds its value when cpu_req=0.
- Simultaneous events:
  - If the granted master's cyc falls on the same edge as another master requests, the result is gnt=00 for that cycle; arbitration happens on the next edge.
  - If all three request together with counter<STARVE_LIMIT, video wins.

Test Plan:
- Reset → gnt=00, s_cyc=0, all acks 0. Assert wb_rst_n=0 mid-way through a video burst → s_cyc drops in the same cycle, and an s_ack in that cycle does not reach vid_ack.
- CPU single read (adr=22'h000100), slave acks 3 cycles after s_stb → s_adr=22'h000100, s_we=0; cpu_ack high for exactly one cycle with m_dat_o=s_dat_i; gnt returns to 00 one cycle after cpu_cyc falls.
- Video burst (cti=010, 4 acks) while snd_cyc and cpu request from mid-burst → all 4 acks go to vid_ack only; then one idle cycle; then gnt=11 (sound before CPU).
- CPU write (sel=4'b0011, dat=32'hDEADBEEF) → s_we=1, s_sel=4'b0011, s_dat_o=32'hDEADBEEF on the cycle after request.
- Video and sound re-request continuously while CPU waits → CPU is granted at the first IDLE after its counter reaches 64; counter reads 0 afterwards.
- vid_cyc, snd_cyc and cpu request asserted on the same edge from IDLE → gnt=10 next cycle; s_stb=0 for at least one cycle between every change of gnt.
